// File: rtl/expr_regr_pkg.sv
// Shared definitions for the expression regression path: result width, MISR FSM
// states, default feedback polynomial and the 90->32 bit fold used by stimulus and scoreboard.
package expr_regr_pkg;

  localparam int Y_W = 90;

  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CHECK,
    DONE
  } misr_state_t;

  // y is raw unsigned bits; the 26-bit top slice is zero-extended, never sign-extended.
  function automatic logic [31:0] fold(input logic [89:0] y);
    return y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
  endfunction

endpackage

// File: rtl/expr_result_misr_core.sv
// Multiple-input signature register: shift left with POLY feedback on the shifted-out
// MSB, XORed with the folded data word. load has priority over en.
module misr_core #(
  parameter int               SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY  = 32'h04C1_1DB7,
  parameter logic [SIG_W-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [SIG_W-1:0] data,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_next;

  always_comb begin
    sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/expr_result_misr.sv
// Compresses NUM_VEC accepted result vectors into a MISR signature and checks it against
// golden_sig. Optional macro EXPR_MISR_LAST_Y_EN adds a last_y debug port holding the final vector.
module expr_result_misr #(
  parameter int               Y_W      = 90,
  parameter int               SIG_W    = 32,
  parameter logic [SIG_W-1:0] POLY     = 32'h04C1_1DB7,
  parameter logic [SIG_W-1:0] SIG_SEED = 32'h0000_0000,
  parameter int               NUM_VEC  = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Y_W-1:0]   in_y,
  input  logic [SIG_W-1:0] golden_sig,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig,
  output logic [15:0]      vec_cnt
`ifdef EXPR_MISR_LAST_Y_EN
  ,
  output logic [Y_W-1:0]   last_y
`endif
);

  import expr_regr_pkg::*;

  localparam logic [15:0] LAST_CNT = 16'(NUM_VEC - 1);

  misr_state_t      state;
  logic             xfer;
  logic             last_xfer;
  logic             restart;
  logic [SIG_W-1:0] fold_y;

  assign xfer      = in_valid && in_ready;
  assign last_xfer = xfer && (vec_cnt == LAST_CNT);
  assign restart   = start && ((state == IDLE) || (state == DONE));
  assign fold_y    = fold(in_y);

  misr_core #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SIG_SEED)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (restart),
    .en    (xfer),
    .data  (fold_y),
    .sig   (sig)
  );

  // in_ready is registered, so it falls on the edge of the final transfer and no extra beat slips in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      vec_cnt  <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            vec_cnt  <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (xfer) begin
            vec_cnt <= vec_cnt + 16'd1;
            if (last_xfer) begin
              state    <= CHECK;
              in_ready <= 1'b0;
            end
          end
        end
        CHECK: begin
          pass  <= (sig == golden_sig);
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE: begin
          if (start) begin
            state    <= RUN;
            vec_cnt  <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef EXPR_MISR_LAST_Y_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_y <= '0;
    end else if (xfer) begin
      last_y <= in_y;
    end
  end
`endif

endmodule

// File: tb/tb_expr_result_misr.sv
// Directed bench: four DUT instances with NUM_VEC = 1, 2, 4, 8 share the data inputs and
// each gets its own start; a vector table drives the single-vector instance.
module tb_expr_result_misr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [89:0] in_y;
  logic [31:0] golden;

  logic        start_a [4];
  logic        rdy_a   [4];
  logic        busy_a  [4];
  logic        done_a  [4];
  logic        pass_a  [4];
  logic [31:0] sig_a   [4];
  logic [15:0] cnt_a   [4];
`ifdef EXPR_MISR_LAST_Y_EN
  logic [89:0] last_y_a [4];
`endif

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    expr_result_misr #(
      .NUM_VEC (1 << gi)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_a[gi]),
      .in_valid   (in_valid),
      .in_ready   (rdy_a[gi]),
      .in_y       (in_y),
      .golden_sig (golden),
      .busy       (busy_a[gi]),
      .done       (done_a[gi]),
      .pass       (pass_a[gi]),
      .sig        (sig_a[gi]),
      .vec_cnt    (cnt_a[gi])
`ifdef EXPR_MISR_LAST_Y_EN
      ,
      .last_y     (last_y_a[gi])
`endif
    );
  end

  typedef struct {
    logic [89:0] y;
    logic [31:0] golden;
    logic [31:0] exp_sig;
    logic        exp_pass;
  } vec_t;

  vec_t tbl [7];

  int bp_valid [9] = '{1, 0, 0, 1, 1, 0, 1, 1, 1};
  int bp_cnt   [9] = '{1, 1, 1, 2, 3, 3, 4, 4, 4};
  int bp_rdy   [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
  int bp_done  [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
  logic [31:0] bp_sig [9] = '{32'h1, 32'h1, 32'h1, 32'h6, 32'h9, 32'h9, 32'h15, 32'h15, 32'h15};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic pulse_start(input int k);
    start_a[k] = 1'b1;
    tick();
    start_a[k] = 1'b0;
  endtask

  // Holds in_valid until instance k is ready, then completes one transfer.
  task automatic send(input int k, input logic [89:0] y);
    int n = 0;
    in_valid = 1'b1;
    in_y     = y;
    while (!rdy_a[k] && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      nvec++;
      nfail++;
      $display("FAIL ready_timeout: inst %0d in_ready stayed 0, expected 1", k);
    end
    tick();
    in_valid = 1'b0;
    in_y     = '0;
  endtask

  initial begin
    tbl[0] = '{y: 90'h0,                                        golden: 32'h0,        exp_sig: 32'h0,        exp_pass: 1'b1};
    tbl[1] = '{y: 90'h1 << 64,                                  golden: 32'h1,        exp_sig: 32'h1,        exp_pass: 1'b1};
    tbl[2] = '{y: (90'h1 << 32) | 90'h1,                        golden: 32'h0,        exp_sig: 32'h0,        exp_pass: 1'b1};
    tbl[3] = '{y: '1,                                           golden: 32'h03FF_FFFF, exp_sig: 32'h03FF_FFFF, exp_pass: 1'b1};
    tbl[4] = '{y: {26'h155_5555, 32'h0000_FFFF, 32'h1234_5678}, golden: 32'h1361_FCD2, exp_sig: 32'h1361_FCD2, exp_pass: 1'b1};
    tbl[5] = '{y: {26'h155_5555, 32'h0000_FFFF, 32'h1234_5678}, golden: 32'h1361_FCD3, exp_sig: 32'h1361_FCD2, exp_pass: 1'b0};
    tbl[6] = '{y: 90'h1 << 89,                                  golden: 32'h0,        exp_sig: 32'h0200_0000, exp_pass: 1'b0};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_y     = '0;
    golden   = '0;
    for (int k = 0; k < 4; k++) start_a[k] = 1'b0;
    tick();
    tick();

    chk("rst_sig", sig_a[0], 32'h0);
    chk("rst_cnt", 32'(cnt_a[0]), 32'h0);
    chk("rst_ready", 32'(rdy_a[0]), 32'h0);
    chk("rst_busy", 32'(busy_a[0]), 32'h0);
    chk("rst_done", 32'(done_a[0]), 32'h0);
    chk("rst_pass", 32'(pass_a[0]), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single-vector runs: fold boundaries and pass/fail compare.
    for (int i = 0; i < 7; i++) begin
      golden = tbl[i].golden;
      pulse_start(0);
      chk("tbl_start_busy", 32'(busy_a[0]), 32'h1);
      chk("tbl_start_sig", sig_a[0], 32'h0);
      chk("tbl_start_cnt", 32'(cnt_a[0]), 32'h0);
      send(0, tbl[i].y);
      chk("tbl_sig", sig_a[0], tbl[i].exp_sig);
      chk("tbl_cnt", 32'(cnt_a[0]), 32'h1);
      chk("tbl_ready_drop", 32'(rdy_a[0]), 32'h0);
      chk("tbl_done_early", 32'(done_a[0]), 32'h0);
      tick();
      chk("tbl_done", 32'(done_a[0]), 32'h1);
      chk("tbl_pass", 32'(pass_a[0]), 32'(tbl[i].exp_pass));
      chk("tbl_busy_off", 32'(busy_a[0]), 32'h0);
      $display("vector %0d: y=%h sig=%h pass=%0b", i, tbl[i].y, sig_a[0], pass_a[0]);
    end

    // NUM_VEC=2: shift behaviour, start ignored in RUN, pass and fail.
    golden = 32'h2;
    pulse_start(1);
    send(1, 90'h1);
    chk("nv2_sig1", sig_a[1], 32'h1);
    chk("nv2_cnt1", 32'(cnt_a[1]), 32'h1);
    chk("nv2_ready1", 32'(rdy_a[1]), 32'h1);
    pulse_start(1);
    chk("nv2_start_ign_cnt", 32'(cnt_a[1]), 32'h1);
    chk("nv2_start_ign_sig", sig_a[1], 32'h1);
    chk("nv2_start_ign_busy", 32'(busy_a[1]), 32'h1);
    send(1, 90'h0);
    chk("nv2_sig2", sig_a[1], 32'h2);
    chk("nv2_cnt2", 32'(cnt_a[1]), 32'h2);
    tick();
    chk("nv2_done", 32'(done_a[1]), 32'h1);
    chk("nv2_pass", 32'(pass_a[1]), 32'h1);
    $display("nv2 run a: sig=%h pass=%0b", sig_a[1], pass_a[1]);

    golden = 32'h3;
    pulse_start(1);
    chk("nv2_restart_busy", 32'(busy_a[1]), 32'h1);
    chk("nv2_restart_done", 32'(done_a[1]), 32'h0);
    chk("nv2_restart_sig", sig_a[1], 32'h0);
    chk("nv2_restart_cnt", 32'(cnt_a[1]), 32'h0);
    send(1, 90'h1);
    send(1, 90'h0);
    tick();
    chk("nv2_fail_sig", sig_a[1], 32'h2);
    chk("nv2_fail_pass", 32'(pass_a[1]), 32'h0);
    $display("nv2 run b: sig=%h pass=%0b", sig_a[1], pass_a[1]);

    golden = 32'h04C1_1DB7;
    pulse_start(1);
    send(1, 90'h8000_0000);
    chk("nv2_msb_sig", sig_a[1], 32'h8000_0000);
    send(1, 90'h0);
    chk("nv2_poly_sig", sig_a[1], 32'h04C1_1DB7);
    tick();
    chk("nv2_poly_pass", 32'(pass_a[1]), 32'h1);
    $display("nv2 run c: sig=%h pass=%0b", sig_a[1], pass_a[1]);

    // NUM_VEC=4 with bubbles and surplus valid beats.
    golden = 32'h15;
    pulse_start(2);
    for (int i = 0; i < 9; i++) begin
      in_valid = bp_valid[i][0];
      in_y     = 90'(i + 1);
      tick();
      chk("bp_cnt", 32'(cnt_a[2]), 32'(bp_cnt[i]));
      chk("bp_sig", sig_a[2], bp_sig[i]);
      chk("bp_ready", 32'(rdy_a[2]), 32'(bp_rdy[i]));
      chk("bp_done", 32'(done_a[2]), 32'(bp_done[i]));
      $display("bp beat %0d: valid=%0d cnt=%0d sig=%h", i, bp_valid[i], cnt_a[2], sig_a[2]);
    end
    in_valid = 1'b0;
    in_y     = '0;
    chk("bp_pass", 32'(pass_a[2]), 32'h1);

    // NUM_VEC=8: asynchronous reset mid-run, then a clean full run.
    golden = 32'hFF;
    pulse_start(3);
    for (int i = 0; i < 3; i++) send(3, 90'h1);
    chk("rr_partial_sig", sig_a[3], 32'h7);
    chk("rr_partial_cnt", 32'(cnt_a[3]), 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_sig", sig_a[3], 32'h0);
    chk("rr_cnt", 32'(cnt_a[3]), 32'h0);
    chk("rr_busy", 32'(busy_a[3]), 32'h0);
    chk("rr_ready", 32'(rdy_a[3]), 32'h0);
    chk("rr_other_done", 32'(done_a[2]), 32'h0);
    chk("rr_other_pass", 32'(pass_a[2]), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start(3);
    for (int i = 0; i < 8; i++) send(3, 90'h1);
    chk("rr_full_sig", sig_a[3], 32'hFF);
    chk("rr_full_cnt", 32'(cnt_a[3]), 32'h8);
    tick();
    chk("rr_full_done", 32'(done_a[3]), 32'h1);
    chk("rr_full_pass", 32'(pass_a[3]), 32'h1);
    $display("nv8 run: sig=%h pass=%0b", sig_a[3], pass_a[3]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
